// File: rtl/sdt_data_mem.sv
// sdt_data_mem: data-side memory responder for the ARM7 single-data-transfer
// (LDR/STR) interface. Word-organised RAM with little-endian byte lanes,
// optional wait states between acceptance and commit, and fault pulses for
// out-of-range addresses and colliding / busy-time requests.
// Build option: define SDT_DATA_MEM_ROTATE_EN to make unaligned word reads
// return the aligned word rotated right by 8*address[1:0] (ARM7 LDR rule);
// without it word reads ignore address[1:0].
module sdt_data_mem #(
    parameter int    ADDR_BITS   = 10,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_write_word_en,
    input  logic        data_write_byte_en,
    input  logic        data_read_word_en,
    input  logic        data_read_byte_en,
    input  logic [31:0] data_write_word_address,
    input  logic [31:0] data_write_byte_address,
    input  logic [31:0] data_write_word_data,
    input  logic [7:0]  data_write_byte_data,
    input  logic [31:0] data_read_word_address,
    input  logic [31:0] data_read_byte_address,
    output logic [31:0] data_read_word_data,
    output logic [7:0]  data_read_byte_data,
    output logic        data_busy,
    output logic        data_done,
    output logic [1:0]  data_fault
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic [1:0] {OP_WR_WORD, OP_WR_BYTE, OP_RD_WORD, OP_RD_BYTE} op_t;

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("sdt_data_mem: WAIT_STATES must be 0..15");
        end
    endgenerate

    logic [31:0] mem [DEPTH];

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    op_t         op_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [7:0]  bdata_reg;

    op_t         req_op;
    logic [31:0] req_addr;
    logic        any_req, multi_req;
    logic        accept, commit, fault_busy;

    op_t         cur_op;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [7:0]  cur_bdata;
    logic        cur_in_range;
    logic [ADDR_BITS-1:0] cur_index;
    logic [1:0]  cur_lane;

    logic        mem_wr;
    logic [3:0]  byte_we;
    logic [31:0] wr_data;
    logic [31:0] rd_aligned, rd_word;
    logic [7:0]  rd_byte;

    assign any_req   = data_write_word_en | data_write_byte_en | data_read_word_en | data_read_byte_en;
    assign multi_req = $countones({data_write_word_en, data_write_byte_en,
                                   data_read_word_en, data_read_byte_en}) > 1;

    // Pick the winning strobe: write_word > write_byte > read_word > read_byte
    always_comb begin
        req_op   = OP_RD_BYTE;
        req_addr = data_read_byte_address;
        if (data_write_word_en) begin
            req_op   = OP_WR_WORD;
            req_addr = data_write_word_address;
        end else if (data_write_byte_en) begin
            req_op   = OP_WR_BYTE;
            req_addr = data_write_byte_address;
        end else if (data_read_word_en) begin
            req_op   = OP_RD_WORD;
            req_addr = data_read_word_address;
        end
    end

    // Next state, wait counter, acceptance and commit decisions
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        commit = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fault_busy = (accept && multi_req) || (state_reg == ST_WAIT && any_req);

    // Commit operands: live request when committing on acceptance, latched otherwise
    always_comb begin
        if (state_reg == ST_WAIT) begin
            cur_op    = op_reg;
            cur_addr  = addr_reg;
            cur_wdata = wdata_reg;
            cur_bdata = bdata_reg;
        end else begin
            cur_op    = req_op;
            cur_addr  = req_addr;
            cur_wdata = data_write_word_data;
            cur_bdata = data_write_byte_data;
        end
    end

    assign cur_in_range = (cur_addr[31:ADDR_BITS+2] == '0);
    assign cur_index    = cur_addr[ADDR_BITS+1:2];
    assign cur_lane     = cur_addr[1:0];

    // Gated by rst_n so a clock edge during reset can never write
    assign mem_wr = commit && cur_in_range && rst_n;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_we[gi] = mem_wr && ((cur_op == OP_WR_WORD) ||
                                 (cur_op == OP_WR_BYTE && cur_lane == 2'(gi)));
            assign wr_data[gi*8 +: 8] = (cur_op == OP_WR_WORD) ? cur_wdata[gi*8 +: 8] : cur_bdata;
        end
    endgenerate

    // RAM write port with per-lane enables; contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) mem[cur_index][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
    end

    assign rd_aligned = mem[cur_index];
    assign rd_byte    = rd_aligned[{cur_lane, 3'b000} +: 8];

`ifdef SDT_DATA_MEM_ROTATE_EN
    // Unaligned word read: rotate right by 8*lane
    always_comb begin
        case (cur_lane)
            2'd1:    rd_word = {rd_aligned[7:0],  rd_aligned[31:8]};
            2'd2:    rd_word = {rd_aligned[15:0], rd_aligned[31:16]};
            2'd3:    rd_word = {rd_aligned[23:0], rd_aligned[31:24]};
            default: rd_word = rd_aligned;
        endcase
    end
`else
    assign rd_word = rd_aligned;
`endif

    // FSM state register; reset aborts any pending access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Request latch and registered outputs (busy, done, fault, read data)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg              <= OP_WR_WORD;
            addr_reg            <= '0;
            wdata_reg           <= '0;
            bdata_reg           <= '0;
            data_read_word_data <= '0;
            data_read_byte_data <= '0;
            data_busy           <= 1'b0;
            data_done           <= 1'b0;
            data_fault          <= 2'b00;
        end else begin
            if (accept) begin
                op_reg    <= req_op;
                addr_reg  <= req_addr;
                wdata_reg <= data_write_word_data;
                bdata_reg <= data_write_byte_data;
            end
            data_busy  <= (state_next == ST_WAIT);
            data_done  <= commit;
            data_fault <= {fault_busy, commit && !cur_in_range};
            if (commit && cur_op == OP_RD_WORD)
                data_read_word_data <= cur_in_range ? rd_word : '0;
            if (commit && cur_op == OP_RD_BYTE)
                data_read_byte_data <= cur_in_range ? rd_byte : '0;
        end
    end
endmodule

// File: tb/tb_sdt_data_mem.sv
// Bench for sdt_data_mem: instance u_ws0 (no wait states) is checked every
// cycle against a transaction-level memory model plus literal expectations;
// instance u_ws3 (three wait states) is checked with directed literal cases.
module tb_sdt_data_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    // ---------------- instance A: WAIT_STATES = 0 ----------------
    logic        rst_a;
    logic        ww_a, wb_a, rw_a, rb_a;
    logic [31:0] wwa_a, wba_a, rwa_a, rba_a, wwd_a;
    logic [7:0]  wbd_a;
    logic [31:0] rwd_a;
    logic [7:0]  rbd_a;
    logic        busy_a, done_a;
    logic [1:0]  fault_a;

    sdt_data_mem #(.ADDR_BITS(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_a),
        .data_write_word_en(ww_a), .data_write_byte_en(wb_a),
        .data_read_word_en(rw_a), .data_read_byte_en(rb_a),
        .data_write_word_address(wwa_a), .data_write_byte_address(wba_a),
        .data_write_word_data(wwd_a), .data_write_byte_data(wbd_a),
        .data_read_word_address(rwa_a), .data_read_byte_address(rba_a),
        .data_read_word_data(rwd_a), .data_read_byte_data(rbd_a),
        .data_busy(busy_a), .data_done(done_a), .data_fault(fault_a)
    );

    // ---------------- instance B: WAIT_STATES = 3 ----------------
    logic        rst_b;
    logic        ww_b, wb_b, rw_b, rb_b;
    logic [31:0] wwa_b, wba_b, rwa_b, rba_b, wwd_b;
    logic [7:0]  wbd_b;
    logic [31:0] rwd_b;
    logic [7:0]  rbd_b;
    logic        busy_b, done_b;
    logic [1:0]  fault_b;

    sdt_data_mem #(.ADDR_BITS(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_b),
        .data_write_word_en(ww_b), .data_write_byte_en(wb_b),
        .data_read_word_en(rw_b), .data_read_byte_en(rb_b),
        .data_write_word_address(wwa_b), .data_write_byte_address(wba_b),
        .data_write_word_data(wwd_b), .data_write_byte_data(wbd_b),
        .data_read_word_address(rwa_b), .data_read_byte_address(rba_b),
        .data_read_word_data(rwd_b), .data_read_byte_data(rbd_b),
        .data_busy(busy_b), .data_done(done_b), .data_fault(fault_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] w, input logic [1:0] l);
`ifdef SDT_DATA_MEM_ROTATE_EN
        return (w >> (8 * l)) | (w << (32 - 8 * l));
`else
        return w;
`endif
    endfunction

    // ---------------- reference model for instance A ----------------
    // Each rising edge the highest-priority strobe takes effect immediately.
    logic [31:0] ref_mem [1024];
    logic [31:0] e_word;
    logic [7:0]  e_byte;
    logic        e_done;
    logic [1:0]  e_fault;

    always @(posedge clk) begin : model
        int          n;
        logic [31:0] a;
        logic [9:0]  wi;
        logic [1:0]  ln;
        logic        inr;
        if (!rst_a) begin
            e_word = '0; e_byte = '0; e_done = 1'b0; e_fault = 2'b00;
        end else begin
            n = int'(ww_a) + int'(wb_a) + int'(rw_a) + int'(rb_a);
            a = ww_a ? wwa_a : wb_a ? wba_a : rw_a ? rwa_a : rba_a;
            inr = (a >> 12) == 0;
            wi = a[11:2];
            ln = a[1:0];
            e_done  = (n != 0);
            e_fault = {n > 1, (n != 0) && !inr};
            if (ww_a) begin
                if (inr) ref_mem[wi] = wwd_a;
            end else if (wb_a) begin
                if (inr) ref_mem[wi][8*ln +: 8] = wbd_a;
            end else if (rw_a) begin
                e_word = inr ? rotr(ref_mem[wi], ln) : 32'h0;
            end else if (rb_a) begin
                e_byte = inr ? ref_mem[wi][8*ln +: 8] : 8'h0;
            end
        end
    end

    // Compare instance A against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_word_vs_model",  rwd_a, e_word);
            check("a_byte_vs_model",  32'(rbd_a), 32'(e_byte));
            check("a_done_vs_model",  32'(done_a), 32'(e_done));
            check("a_fault_vs_model", 32'(fault_a), 32'(e_fault));
            check("a_busy_zero",      32'(busy_a), 32'h0);
        end
    end

    // One request on instance A: s = {ww, wb, rw, rb}, common address
    task automatic req0(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        {ww_a, wb_a, rw_a, rb_a} = s;
        wwa_a = a; wba_a = a; rwa_a = a; rba_a = a;
        wwd_a = d; wbd_a = d[7:0];
        @(posedge clk); #1;
        {ww_a, wb_a, rw_a, rb_a} = 4'b0000;
        $display("[TB] ws0 req=%b addr=%h data=%h -> word=%h byte=%h done=%b fault=%b",
                 s, a, d, rwd_a, rbd_a, done_a, fault_a);
    endtask

    // One request on instance B, returning after the acceptance edge
    task automatic req3(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        {ww_b, wb_b, rw_b, rb_b} = s;
        wwa_b = a; wba_b = a; rwa_b = a; rba_b = a;
        wwd_b = d; wbd_b = d[7:0];
        @(posedge clk); #1;
        {ww_b, wb_b, rw_b, rb_b} = 4'b0000;
        $display("[TB] ws3 req=%b addr=%h data=%h busy=%b fault=%b", s, a, d, busy_b, fault_b);
    endtask

    task automatic edges3(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] exp_rot;
    logic [5:0]  done_mask;
    logic [1:0]  f1;
    int          busy_cnt;
    int          late_done;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        {ww_a, wb_a, rw_a, rb_a} = 4'b0000; {ww_b, wb_b, rw_b, rb_b} = 4'b0000;
        wwa_a = '0; wba_a = '0; rwa_a = '0; rba_a = '0; wwd_a = '0; wbd_a = '0;
        wwa_b = '0; wba_b = '0; rwa_b = '0; rba_b = '0; wwd_b = '0; wbd_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("a_reset_word",  rwd_a, 32'h0);
        check("a_reset_byte",  32'(rbd_a), 32'h0);
        check("a_reset_busy",  32'(busy_a), 32'h0);
        check("a_reset_done",  32'(done_a), 32'h0);
        check("a_reset_fault", 32'(fault_a), 32'h0);
        check("b_reset_word",  rwd_b, 32'h0);
        check("b_reset_byte",  32'(rbd_b), 32'h0);
        check("b_reset_busy",  32'(busy_b), 32'h0);
        check("b_reset_done",  32'(done_b), 32'h0);
        check("b_reset_fault", 32'(fault_b), 32'h0);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        chk_en = 1'b1;

        // Preload the first 16 words so every later read has a known value
        for (int i = 0; i < 16; i++) req0(4'b1000, 32'(i * 4), $urandom);

        // Word store / load
        req0(4'b1000, 32'h10, 32'hDEADBEEF);
        check("a_store_done", 32'(done_a), 32'h1);
        req0(4'b0010, 32'h10, 32'h0);
        check("a_load_10", rwd_a, 32'hDEADBEEF);
        check("a_load_done", 32'(done_a), 32'h1);

        // Byte lanes
        req0(4'b1000, 32'h20, 32'h11223344);
        req0(4'b0100, 32'h22, 32'h000000AA);
        req0(4'b0001, 32'h20, 32'h0); check("a_byte_20", 32'(rbd_a), 32'h44);
        req0(4'b0001, 32'h21, 32'h0); check("a_byte_21", 32'(rbd_a), 32'h33);
        req0(4'b0001, 32'h22, 32'h0); check("a_byte_22", 32'(rbd_a), 32'hAA);
        req0(4'b0001, 32'h23, 32'h0); check("a_byte_23", 32'(rbd_a), 32'h11);
        req0(4'b0010, 32'h20, 32'h0); check("a_word_20", rwd_a, 32'h11AA3344);

        // Unaligned word load
        req0(4'b1000, 32'h20, 32'h11223344);
        req0(4'b0010, 32'h21, 32'h0);
`ifdef SDT_DATA_MEM_ROTATE_EN
        exp_rot = 32'h44112233;
`else
        exp_rot = 32'h11223344;
`endif
        check("a_word_21_unaligned", rwd_a, exp_rot);

        // Collision: write_word wins over read_byte
        req0(4'b1001, 32'h30, 32'h55667788);
        check("a_coll_fault", 32'(fault_a), 32'h2);
        check("a_coll_byte_hold", 32'(rbd_a), 32'h11);
        req0(4'b0000, 32'h0, 32'h0);
        check("a_coll_fault_one_cycle", 32'(fault_a), 32'h0);
        req0(4'b0010, 32'h30, 32'h0);
        check("a_coll_write_done", rwd_a, 32'h55667788);

        // Out of range
        req0(4'b0010, 32'h1000, 32'h0);
        check("a_oor_read_word", rwd_a, 32'h0);
        check("a_oor_read_fault", 32'(fault_a), 32'h1);
        check("a_oor_read_done", 32'(done_a), 32'h1);
        req0(4'b1000, 32'h1010, 32'hFFFFFFFF);
        check("a_oor_write_fault", 32'(fault_a), 32'h1);
        req0(4'b0010, 32'h10, 32'h0);
        check("a_oor_mem_unchanged", rwd_a, 32'hDEADBEEF);

        // Randomized traffic on instance A, checked against the model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ww_a = ($urandom_range(0, 3) == 0);
            wb_a = ($urandom_range(0, 3) == 0);
            rw_a = ($urandom_range(0, 3) == 0);
            rb_a = ($urandom_range(0, 3) == 0);
            wwa_a = $urandom_range(0, 63);
            wba_a = $urandom_range(0, 63);
            rwa_a = $urandom_range(0, 63);
            rba_a = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) wwa_a = wwa_a | (32'h1 << $urandom_range(12, 31));
            if ($urandom_range(0, 7) == 0) rwa_a = rwa_a | (32'h1 << $urandom_range(12, 31));
            if ($urandom_range(0, 7) == 0) rba_a = rba_a | (32'h1 << $urandom_range(12, 31));
            wwd_a = $urandom;
            wbd_a = 8'($urandom);
            $display("[TB] ws0 rnd req=%b ww@%h=%h wb@%h=%h rw@%h rb@%h",
                     {ww_a, wb_a, rw_a, rb_a}, wwa_a, wwd_a, wba_a, wbd_a, rwa_a, rba_a);
        end
        @(negedge clk);
        {ww_a, wb_a, rw_a, rb_a} = 4'b0000;
        @(negedge clk);
        chk_en = 1'b0;

        // Instance B: store, then a second strobe one cycle later
        busy_cnt = 0; done_mask = '0; f1 = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ww_b = (k == 0); wwa_b = 32'h30; wwd_b = 32'hCAFEF00D;
            rb_b = (k == 1); rba_b = 32'h30;
            @(posedge clk); #1;
            ww_b = 1'b0; rb_b = 1'b0;
            if (busy_b) busy_cnt++;
            if (done_b) done_mask[k] = 1'b1;
            if (k == 1) f1 = fault_b;
            $display("[TB] ws3 edge %0d busy=%b done=%b fault=%b", k, busy_b, done_b, fault_b);
        end
        check("b_busy_cycles", 32'(busy_cnt), 32'd3);
        check("b_done_edge", 32'(done_mask), 32'b001000);
        check("b_busy_strobe_fault", 32'(f1), 32'h2);

        req3(4'b0010, 32'h30, 32'h0);
        check("b_read_busy", 32'(busy_b), 32'h1);
        edges3(3);
        check("b_readback", rwd_b, 32'hCAFEF00D);
        check("b_read_done", 32'(done_b), 32'h1);
        check("b_ignored_byte_read", 32'(rbd_b), 32'h0);

        // Reset in the middle of a pending write aborts it
        req3(4'b1000, 32'h30, 32'h12345678);
        check("b_wr_busy", 32'(busy_b), 32'h1);
        edges3(1);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("b_rst_busy_immediate", 32'(busy_b), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        late_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done_b) late_done++;
        end
        check("b_no_commit_after_rst", 32'(late_done), 32'h0);
        req3(4'b0010, 32'h30, 32'h0);
        edges3(3);
        check("b_rst_write_aborted", rwd_b, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
